// File: rtl/ref_cache_req_arbiter_if.sv
// Requester / cache bundle for the reference-cache request arbiter.
// master = arbiter side, slave = requesters plus cache side.
interface ref_cache_req_arbiter_if #(
    parameter int COORD_W = 13,
    parameter int DIM_W   = 7
);
    logic                      req0_valid;
    logic                      req0_ready;
    logic signed [COORD_W-1:0] req0_x;
    logic signed [COORD_W-1:0] req0_y;
    logic        [DIM_W-1:0]   req0_w;
    logic        [DIM_W-1:0]   req0_h;

    logic                      req1_valid;
    logic                      req1_ready;
    logic signed [COORD_W-1:0] req1_x;
    logic signed [COORD_W-1:0] req1_y;
    logic        [DIM_W-1:0]   req1_w;
    logic        [DIM_W-1:0]   req1_h;

    logic                      cache_valid_in;
    logic                      cache_idle_in;
    logic signed [COORD_W-1:0] cache_x;
    logic signed [COORD_W-1:0] cache_y;
    logic        [DIM_W-1:0]   cache_w;
    logic        [DIM_W-1:0]   cache_h;
    logic                      cache_rsp_valid;

    logic                      rsp0_valid;
    logic                      rsp1_valid;

    modport master (
        input  req0_valid, req0_x, req0_y, req0_w, req0_h,
        input  req1_valid, req1_x, req1_y, req1_w, req1_h,
        input  cache_idle_in, cache_rsp_valid,
        output req0_ready, req1_ready,
        output cache_valid_in, cache_x, cache_y, cache_w, cache_h,
        output rsp0_valid, rsp1_valid
    );

    modport slave (
        output req0_valid, req0_x, req0_y, req0_w, req0_h,
        output req1_valid, req1_x, req1_y, req1_w, req1_h,
        output cache_idle_in, cache_rsp_valid,
        input  req0_ready, req1_ready,
        input  cache_valid_in, cache_x, cache_y, cache_w, cache_h,
        input  rsp0_valid, rsp1_valid
    );
endinterface

// File: rtl/ref_cache_req_arbiter.sv
// Round-robin arbiter of two block requesters onto one reference cache,
// with an in-order tag FIFO that steers cache responses back.
module ref_cache_req_arbiter #(
    parameter  int COORD_W   = 13,
    parameter  int DIM_W     = 7,
    parameter  int TAG_DEPTH = 4,
    localparam int CNT_W     = $clog2(TAG_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ref_cache_req_arbiter_if.master bus,
    output logic [CNT_W-1:0]      outstanding_cnt,
    output logic                  err_unexpected_rsp
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic                      last_q, last_d;
    logic                      tag_q, tag_d;
    logic signed [COORD_W-1:0] x_q, x_d;
    logic signed [COORD_W-1:0] y_q, y_d;
    logic        [DIM_W-1:0]   w_q, w_d;
    logic        [DIM_W-1:0]   h_q, h_d;
    logic [TAG_DEPTH-1:0]      fifo_q, fifo_d;
    logic [PTR_W-1:0]          wr_q, wr_d;
    logic [PTR_W-1:0]          rd_q, rd_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;

    logic full;
    logic empty;
    logic can_grant;
    logic gnt0;
    logic gnt1;
    logic accept;
    logic pop;
    logic head;

    // Grants and strobes are masked while reset is held high.
    always_comb begin
        full      = (cnt_q == FULL_CNT);
        empty     = (cnt_q == '0);
        can_grant = (state_q == IDLE) && !full && !reset;
        gnt0      = can_grant && bus.req0_valid
                    && (!bus.req1_valid || last_q);
        gnt1      = can_grant && bus.req1_valid && !gnt0;
        accept    = (state_q == ISSUE) && bus.cache_idle_in;
        pop       = bus.cache_rsp_valid && !empty && !reset;
        head      = fifo_q[rd_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cache_valid_in = (state_q == ISSUE);
        bus.req0_ready     = gnt0;
        bus.req1_ready     = gnt1;
        bus.rsp0_valid     = pop && !head;
        bus.rsp1_valid     = pop && head;
        bus.cache_x        = x_q;
        bus.cache_y        = y_q;
        bus.cache_w        = w_q;
        bus.cache_h        = h_q;
        outstanding_cnt    = cnt_q;
        err_unexpected_rsp = err_q;
    end

    always_comb begin
        last_d = last_q;
        tag_d  = tag_q;
        x_d    = x_q;
        y_d    = y_q;
        w_d    = w_q;
        h_d    = h_q;
        if (gnt0) begin
            x_d    = bus.req0_x;
            y_d    = bus.req0_y;
            w_d    = bus.req0_w;
            h_d    = bus.req0_h;
            tag_d  = 1'b0;
            last_d = 1'b0;
        end else if (gnt1) begin
            x_d    = bus.req1_x;
            y_d    = bus.req1_y;
            w_d    = bus.req1_w;
            h_d    = bus.req1_h;
            tag_d  = 1'b1;
            last_d = 1'b1;
        end
    end

    // Pop reads fifo_q, so a same-cycle push never shadows the head.
    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (accept) begin
            fifo_d[wr_q] = tag_q;
            wr_d         = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q || (bus.cache_rsp_valid && empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
            tag_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= '0;
            h_q    <= '0;
            fifo_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            tag_q  <= tag_d;
            x_q    <= x_d;
            y_q    <= y_d;
            w_q    <= w_d;
            h_q    <= h_d;
            fifo_q <= fifo_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_ref_cache_req_arbiter.sv
// Scoreboard bench for ref_cache_req_arbiter: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_ref_cache_req_arbiter;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [12:0] x;
        logic [12:0] y;
        logic [6:0]  w;
        logic [6:0]  h;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] cnt;
    logic       err;

    ref_cache_req_arbiter_if #(.COORD_W(13), .DIM_W(7)) bus ();

    ref_cache_req_arbiter #(
        .COORD_W(13),
        .DIM_W(7),
        .TAG_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .outstanding_cnt(cnt),
        .err_unexpected_rsp(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model
    int   m_tags[$];
    exp_t exp_req_q[$];
    int   exp_rsp_q[$];
    bit   m_busy, m_last, m_cur, m_err;
    bit   pend0, pend1;
    bit   chk_en = 1'b0;
    bit   e_rdy0, e_rdy1, e_cv, e_rsp0, e_rsp1, e_err;
    int   e_cnt;
    bit   use_fix = 1'b0;
    logic [12:0] fix_x, fix_y;
    logic [6:0]  fix_w, fix_h;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        m_tags.delete();
        exp_req_q.delete();
        exp_rsp_q.delete();
        m_busy = 0;
        m_last = 1;
        m_cur  = 0;
        m_err  = 0;
        pend0  = 0;
        pend1  = 0;
    endtask

    task automatic drive_cycle(input bit v0, input bit v1,
                               input bit idle, input bit rsp);
        int   g;
        int   t;
        exp_t e;
        @(posedge clk);
        #1;
        if (!pend0) begin
            bus.req0_valid = v0;
            if (v0) begin
                bus.req0_x = use_fix ? fix_x : 13'($urandom);
                bus.req0_y = use_fix ? fix_y : 13'($urandom);
                bus.req0_w = use_fix ? fix_w : 7'($urandom);
                bus.req0_h = use_fix ? fix_h : 7'($urandom);
            end
        end
        if (!pend1) begin
            bus.req1_valid = v1;
            if (v1) begin
                bus.req1_x = 13'($urandom);
                bus.req1_y = 13'($urandom);
                bus.req1_w = 7'($urandom);
                bus.req1_h = 7'($urandom);
            end
        end
        bus.cache_idle_in   = idle;
        bus.cache_rsp_valid = rsp;
        e_cv   = m_busy;
        e_cnt  = m_tags.size();
        e_err  = m_err;
        e_rsp0 = 0;
        e_rsp1 = 0;
        g = -1;
        if (!m_busy && m_tags.size() < DEPTH) begin
            if (bus.req0_valid && bus.req1_valid) g = m_last ? 0 : 1;
            else if (bus.req0_valid) g = 0;
            else if (bus.req1_valid) g = 1;
        end
        e_rdy0 = (g == 0);
        e_rdy1 = (g == 1);
        if (rsp) begin
            if (m_tags.size() > 0) begin
                t = m_tags.pop_front();
                exp_rsp_q.push_back(t);
                e_rsp0 = (t == 0);
                e_rsp1 = (t == 1);
            end else begin
                m_err = 1;
            end
        end
        if (m_busy && idle) begin
            m_tags.push_back(int'(m_cur));
            m_busy = 0;
        end
        if (g >= 0) begin
            m_busy = 1;
            m_last = g[0];
            m_cur  = g[0];
            if (g == 0) begin
                e.x = bus.req0_x; e.y = bus.req0_y;
                e.w = bus.req0_w; e.h = bus.req0_h;
            end else begin
                e.x = bus.req1_x; e.y = bus.req1_y;
                e.w = bus.req1_w; e.h = bus.req1_h;
            end
            exp_req_q.push_back(e);
        end
        pend0  = bus.req0_valid && (g != 0);
        pend1  = bus.req1_valid && (g != 1);
        chk_en = 1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 60; i++) begin
            if (m_tags.size() == 0 && !m_busy && !pend0 && !pend1) break;
            drive_cycle(0, 0, 1, m_tags.size() > 0);
        end
        if (i == 60) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: got busy expected idle");
        end
    endtask

    exp_t mon_e;
    int   mon_t;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req0_ready", bus.req0_ready, e_rdy0);
            chk("req1_ready", bus.req1_ready, e_rdy1);
            chk("cache_valid_in", bus.cache_valid_in, e_cv);
            chk("outstanding_cnt", cnt, e_cnt);
            chk("err_unexpected_rsp", err, e_err);
            chk("rsp0_valid", bus.rsp0_valid, e_rsp0);
            chk("rsp1_valid", bus.rsp1_valid, e_rsp1);
            if (bus.cache_valid_in) begin
                if (exp_req_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL cache_req: got request expected none");
                end else begin
                    mon_e = exp_req_q[0];
                    chk("cache_x", {bus.cache_x}, {mon_e.x});
                    chk("cache_y", {bus.cache_y}, {mon_e.y});
                    chk("cache_w", bus.cache_w, mon_e.w);
                    chk("cache_h", bus.cache_h, mon_e.h);
                    if (bus.cache_idle_in) void'(exp_req_q.pop_front());
                end
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rsp_tag: got strobe expected none");
                end else begin
                    mon_t = exp_rsp_q.pop_front();
                    chk("rsp_tag", bus.rsp1_valid, mon_t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_x = 0; bus.req0_y = 0; bus.req0_w = 0; bus.req0_h = 0;
        bus.req1_x = 0; bus.req1_y = 0; bus.req1_w = 0; bus.req1_h = 0;
        bus.cache_idle_in = 0;
        bus.cache_rsp_valid = 0;
        model_init();

        // reset state, with live inputs to prove the strobes are masked
        #2;
        reset = 1;
        bus.req0_valid = 1;
        bus.cache_idle_in = 1;
        bus.cache_rsp_valid = 1;
        #1;
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_cache_valid", bus.cache_valid_in, 0);
        chk("rst_cache_x", {bus.cache_x}, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp0", bus.rsp0_valid, 0);
        bus.req0_valid = 0;
        bus.cache_rsp_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;

        // single request with known coordinates
        use_fix = 1;
        fix_x = 13'd16; fix_y = 13'd8; fix_w = 7'd7; fix_h = 7'd7;
        drive_cycle(1, 0, 1, 0);
        use_fix = 0;
        drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0);

        // tie fairness then in-order responses
        repeat (8) drive_cycle(1, 1, 1, 0);
        drain();

        // backpressure during ISSUE
        drive_cycle(1, 0, 0, 0);
        repeat (5) drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0);
        drain();

        // full: stall at DEPTH, one response frees a slot
        repeat (10) drive_cycle(1, 1, 1, 0);
        drive_cycle(1, 1, 1, 1);
        repeat (3) drive_cycle(1, 1, 1, 0);
        drain();

        // simultaneous push and pop at count 2
        drive_cycle(1, 0, 1, 0);
        drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 1, 1, 0);
        drive_cycle(0, 0, 1, 0);
        drive_cycle(1, 0, 1, 0);
        drive_cycle(0, 0, 1, 1);
        drive_cycle(0, 0, 1, 0);
        drain();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive_cycle($urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) != 0,
                        m_tags.size() > 0 && $urandom_range(0, 2) == 0);
        end
        drain();

        // unexpected response is sticky
        drive_cycle(0, 0, 1, 1);
        repeat (3) drive_cycle(0, 0, 1, 0);

        // reset in the middle of an ISSUE
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        @(negedge clk);
        #2;
        chk_en = 0;
        reset = 1;
        bus.req0_valid = 1;
        bus.cache_idle_in = 1;
        #1;
        chk("midrst_cache_valid", bus.cache_valid_in, 0);
        chk("midrst_req0_ready", bus.req0_ready, 0);
        chk("midrst_err", err, 0);
        @(posedge clk);
        #1;
        bus.req0_valid = 0;
        reset = 0;
        model_init();
        drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 1, 1);
        drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 1, 0);

        @(posedge clk);
        #1;
        chk_en = 0;
        chk("rsp_q_left", exp_rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
